// File: rtl/jtpopeye_dma_pkg.sv
// Shared types and constants for the Popeye object DMA initiator.
package jtpopeye_dma_pkg;

    localparam int unsigned PipeDepth = 2;
    localparam int unsigned AddrWidth = 10;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StXfer,
        StDrain,
        StRel
    } state_e;

endpackage

// File: rtl/jtpopeye_dma_pipe.sv
// Two-stage address/valid delay line: RAM samples the address one tick after it is presented,
// and the returned byte is written to the object buffer one tick after that.
module jtpopeye_dma_pipe
    import jtpopeye_dma_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen_i,
    input  logic                 valid_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [7:0]           data_i,
    output logic [AddrWidth-1:0] obj_addr_o,
    output logic [7:0]           obj_data_o,
    output logic                 obj_we_o
);

    logic                 s1_valid_q, s1_valid_d;
    logic [AddrWidth-1:0] s1_addr_q, s1_addr_d;
    logic [AddrWidth-1:0] obj_addr_q, obj_addr_d;
    logic [7:0]           obj_data_q, obj_data_d;
    logic                 obj_we_q, obj_we_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        obj_addr_d = obj_addr_q;
        obj_data_d = obj_data_q;
        // The strobe is rebuilt every clk so it stays one clk wide at any cen duty cycle.
        obj_we_d   = 1'b0;
        if (cen_i) begin
            s1_valid_d = valid_i;
            s1_addr_d  = addr_i;
            if (s1_valid_q) begin
                obj_addr_d = s1_addr_q;
                obj_data_d = data_i;
                obj_we_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            obj_addr_q <= '0;
            obj_data_q <= '0;
            obj_we_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            obj_addr_q <= obj_addr_d;
            obj_data_q <= obj_data_d;
            obj_we_q   <= obj_we_d;
        end
    end

    assign obj_addr_o = obj_addr_q;
    assign obj_data_o = obj_data_q;
    assign obj_we_o   = obj_we_q;

endmodule

// File: rtl/jtpopeye_dma.sv
// Object DMA initiator: on each VB rising edge, request the Z80 bus and copy XFER_LEN bytes of
// the upper main RAM into the object buffer. Optional REQ abort: JTPOPEYE_DMA_TIMEOUT_EN.
module jtpopeye_dma
    import jtpopeye_dma_pkg::*;
#(
    parameter int unsigned XFER_LEN = 1024,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                 rst_n,
    input  logic                 clk,
    input  logic                 cpu_cen,
    input  logic                 VB,
    output logic                 busrq_n,
    input  logic                 busak_n,
    output logic                 dma_cs,
    output logic [AddrWidth-1:0] AD_DMA,
    input  logic [7:0]           DD_DMA,
    output logic [AddrWidth-1:0] obj_addr,
    output logic [7:0]           obj_data,
    output logic                 obj_we,
    output logic                 busy,
    output logic                 timeout
);

    localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(XFER_LEN - 1);
    localparam logic [1:0]           DrainLast = 2'(PipeDepth - 1);

    state_e               state_q, state_d;
    logic                 vb_q, vb_d;
    logic                 busrq_q, busrq_d;
    logic                 dma_cs_q, dma_cs_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [1:0]           drain_q, drain_d;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
`endif

    always_comb begin
        state_d  = state_q;
        vb_d     = vb_q;
        busrq_d  = busrq_q;
        dma_cs_d = dma_cs_q;
        addr_d   = addr_q;
        drain_d  = drain_q;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        if (cpu_cen) begin
            vb_d = VB;
            unique case (state_q)
                StIdle: begin
                    if (VB && !vb_q) begin
                        state_d = StReq;
                        busrq_d = 1'b0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
                StReq: begin
                    if (!busak_n) begin
                        state_d  = StXfer;
                        dma_cs_d = 1'b1;
                        addr_d   = '0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                        timeout_d = 1'b0;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_d   = StIdle;
                        busrq_d   = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
`endif
                    end
                end
                StXfer: begin
                    if (addr_q == LastAddr) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                StDrain: begin
                    // Bus stays ours until the last in-flight byte has been captured.
                    if (drain_q == DrainLast) begin
                        state_d  = StRel;
                        dma_cs_d = 1'b0;
                        busrq_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                StRel: begin
                    if (busak_n) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            vb_q     <= 1'b0;
            busrq_q  <= 1'b1;
            dma_cs_q <= 1'b0;
            addr_q   <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            vb_q     <= vb_d;
            busrq_q  <= busrq_d;
            dma_cs_q <= dma_cs_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
        end
    end

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    jtpopeye_dma_pipe u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen_i      (cpu_cen),
        .valid_i    (state_q == StXfer),
        .addr_i     (addr_q),
        .data_i     (DD_DMA),
        .obj_addr_o (obj_addr),
        .obj_data_o (obj_data),
        .obj_we_o   (obj_we)
    );

    assign busrq_n = busrq_q;
    assign dma_cs  = dma_cs_q;
    assign AD_DMA  = addr_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Self-checking bench: a full-length and a single-byte DMA instance against a RAM/bus model.
module tb_jtpopeye_dma;

    localparam int L = 1024;

    typedef struct {
        int div;        // cen period in clk; 0 = random cen
        int ack;        // bus-acknowledge delay in ticks
        bit rnd;        // random RAM contents instead of addr ^ 8'h5A
        bit glitch;     // extra VB edge in the middle of the transfer
        int exp_writes;
        int exp_rel;    // release tick relative to T0
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, cpu_cen = 1'b0, vb, vb1;
    logic       busak_n = 1'b1, busak1_n = 1'b1;
    logic [7:0] dd = 8'h00, dd1 = 8'h00;
    logic [7:0] ram [0:1023];

    logic       busrq_n, dma_cs, obj_we, busy, timeout;
    logic [9:0] AD_DMA, obj_addr;
    logic [7:0] obj_data;
    logic       busrq1_n, dma_cs1, obj_we1, busy1, timeout1;
    logic [9:0] ad1, obj_addr1;
    logic [7:0] obj_data1;

    int checks = 0, errors = 0;
    int div = 1, cen_cnt = 0, ack_delay = 0;
    bit ack_en = 1'b1;
    int ack_cnt = 0, ack1_cnt = 0;
    vec_t vecs [5];

    jtpopeye_dma #(.XFER_LEN(L), .TIMEOUT(16)) u_dut (
        .rst_n(rst_n), .clk(clk), .cpu_cen(cpu_cen), .VB(vb), .busrq_n(busrq_n),
        .busak_n(busak_n), .dma_cs(dma_cs), .AD_DMA(AD_DMA), .DD_DMA(dd),
        .obj_addr(obj_addr), .obj_data(obj_data), .obj_we(obj_we), .busy(busy),
        .timeout(timeout)
    );

    jtpopeye_dma #(.XFER_LEN(1)) u_dut1 (
        .rst_n(rst_n), .clk(clk), .cpu_cen(cpu_cen), .VB(vb1), .busrq_n(busrq1_n),
        .busak_n(busak1_n), .dma_cs(dma_cs1), .AD_DMA(ad1), .DD_DMA(dd1),
        .obj_addr(obj_addr1), .obj_data(obj_data1), .obj_we(obj_we1), .busy(busy1),
        .timeout(timeout1)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (div == 0) cpu_cen = ($urandom_range(0, 1) == 1);
            else begin
                cpu_cen = (cen_cnt == 0);
                cen_cnt = (cen_cnt + 1 >= div) ? 0 : cen_cnt + 1;
            end
        end
    end

    // Synchronous RAM and bus-acknowledge responders.
    always @(posedge clk) begin
        if (cpu_cen) begin
            dd  <= ram[AD_DMA];
            dd1 <= ram[ad1];
            if (busrq_n) begin
                ack_cnt <= 0;
                busak_n <= 1'b1;
            end else if (ack_en && ack_cnt >= ack_delay) busak_n <= 1'b0;
            else ack_cnt <= ack_cnt + 1;
            if (busrq1_n) begin
                ack1_cnt <= 0;
                busak1_n <= 1'b1;
            end else if (ack1_cnt >= ack_delay) busak1_n <= 1'b0;
            else ack1_cnt <= ack1_cnt + 1;
        end
    end

    // Event log: tick indices of T0, writes and bus releases.
    int tick_cnt = 0, wide_err = 0;
    logic prev_cen = 1'b0, prev_busrq = 1'b1, prev_busrq1 = 1'b1;
    int wr_addr[$], wr_data[$], wr_tick[$], t0_q[$], rel_q[$];
    int wr1_addr[$], wr1_data[$], wr1_tick[$], t01_q[$], rel1_q[$];

    always @(posedge clk) begin
        if (obj_we) begin
            wr_addr.push_back(int'(obj_addr));
            wr_data.push_back(int'(obj_data));
            wr_tick.push_back(tick_cnt);
            if (!prev_cen) wide_err <= wide_err + 1;
        end
        if (obj_we1) begin
            wr1_addr.push_back(int'(obj_addr1));
            wr1_data.push_back(int'(obj_data1));
            wr1_tick.push_back(tick_cnt);
        end
        if (busrq_n && !prev_busrq) rel_q.push_back(tick_cnt);
        if (busrq1_n && !prev_busrq1) rel1_q.push_back(tick_cnt);
        if (cpu_cen) begin
            tick_cnt <= tick_cnt + 1;
            if (!busrq_n && !dma_cs && !busak_n) t0_q.push_back(tick_cnt + 1);
            if (!busrq1_n && !dma_cs1 && !busak1_n) t01_q.push_back(tick_cnt + 1);
        end
        prev_cen    <= cpu_cen;
        prev_busrq  <= busrq_n;
        prev_busrq1 <= busrq1_n;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        int g;
        repeat (n) begin
            g = 0;
            do begin
                @(posedge clk);
                g++;
            end while (!cpu_cen && g < 1000);
        end
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        while (int'(AD_DMA) != a && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("reach_addr", int'(AD_DMA), a);
    endtask

    task automatic start_xfer(input bit both);
        @(negedge clk);
        vb  = 1'b0;
        vb1 = 1'b0;
        tick_wait(1);
        @(negedge clk);
        vb = 1'b1;
        if (both) vb1 = 1'b1;
        tick_wait(1);
        #1;
        check("vb_to_busrq", busrq_n, 0);
        check("busy_on_req", busy, 1);
        if (both) check("d1_vb_to_busrq", busrq1_n, 0);
    endtask

    task automatic run_xfer(input vec_t v);
        int wb, tb0, rb, web, wb1, tb1, rb1, t0, t01, n, bad, cnt;
        div = v.div;
        ack_delay = v.ack;
        for (int i = 0; i < L; i++) ram[i] = v.rnd ? 8'($urandom) : (8'(i) ^ 8'h5A);
        wb = wr_addr.size(); tb0 = t0_q.size(); rb = rel_q.size(); web = wide_err;
        wb1 = wr1_addr.size(); tb1 = t01_q.size(); rb1 = rel1_q.size();
        start_xfer(1'b1);
        if (v.glitch) begin
            wait_addr(100);
            vb = 1'b0;
            tick_wait(2);
            @(negedge clk);
            vb = 1'b1;
        end
        n = 0;
        while ((busy || busy1) && n < 50000) begin
            @(negedge clk);
            n++;
        end
        check("done_in_budget", int'(n < 50000), 1);
        check("t0_count", t0_q.size() - tb0, 1);
        t0 = (t0_q.size() > tb0) ? t0_q[tb0] : 0;
        cnt = wr_addr.size() - wb;
        check("wr_count", cnt, v.exp_writes);
        bad = 0;
        for (int i = 0; i < cnt && i < L; i++) begin
            if (wr_addr[wb+i] != i || wr_data[wb+i] != int'(ram[i]) || wr_tick[wb+i] != t0 + 2 + i)
                bad++;
        end
        check("wr_order_data_tick", bad, 0);
        check("rel_tick", (rel_q.size() > rb) ? rel_q[rb] - t0 : -1, v.exp_rel);
        check("we_one_clk", wide_err - web, 0);
        check("idle_busrq_n", busrq_n, 1);
        check("idle_dma_cs", dma_cs, 0);
        check("timeout_clear", timeout, 0);
        t01 = (t01_q.size() > tb1) ? t01_q[tb1] : 0;
        check("d1_t0_count", t01_q.size() - tb1, 1);
        check("d1_wr_count", wr1_addr.size() - wb1, 1);
        if (wr1_addr.size() > wb1) begin
            check("d1_wr_addr", wr1_addr[wb1], 0);
            check("d1_wr_data", wr1_data[wb1], int'(ram[0]));
            check("d1_wr_tick", wr1_tick[wb1] - t01, 2);
        end
        check("d1_rel_tick", (rel1_q.size() > rb1) ? rel1_q[rb1] - t01 : -1, 3);
        check("d1_timeout", timeout1, 0);
    endtask

    initial begin
        vecs[0] = '{1, 3, 1'b0, 1'b0, L, L + 2};
        vecs[1] = '{4, 0, 1'b1, 1'b0, L, L + 2};
        vecs[2] = '{2, 5, 1'b1, 1'b1, L, L + 2};
        vecs[3] = '{0, 1, 1'b1, 1'b0, L, L + 2};
        vecs[4] = '{1, 2, 1'b1, 1'b0, L, L + 2};
        for (int i = 0; i < L; i++) ram[i] = 8'h00;

        rst_n = 1'b0;
        vb    = 1'b0;
        vb1   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busrq_n", busrq_n, 1);
        check("rst_dma_cs", dma_cs, 0);
        check("rst_ad_dma", int'(AD_DMA), 0);
        check("rst_obj_addr", int'(obj_addr), 0);
        check("rst_obj_data", int'(obj_data), 0);
        check("rst_obj_we", obj_we, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_xfer(vecs[i]);

        // Asynchronous reset in the middle of a transfer.
        div = 1;
        ack_delay = 2;
        start_xfer(1'b0);
        wait_addr(300);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busrq_n", busrq_n, 1);
        check("midrst_dma_cs", dma_cs, 0);
        check("midrst_obj_we", obj_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ad_dma", int'(AD_DMA), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
        begin
            int wb;
            div = 1;
            ack_en = 1'b0;
            wb = wr_addr.size();
            start_xfer(1'b0);
            tick_wait(15);
            #1;
            check("to_still_req", busrq_n, 0);
            tick_wait(1);
            #1;
            check("to_busrq_n", busrq_n, 1);
            check("to_flag", timeout, 1);
            check("to_busy", busy, 0);
            check("to_no_writes", wr_addr.size() - wb, 0);
            ack_en = 1'b1;
        end
`endif

        run_xfer(vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
